// File: rtl/sr_bank_driver.sv
// sr_bank_driver
//   Command-side driver for a bank of WIDTH synchronous SR flip-flops. A target word is
//   accepted over valid/ready, compared against a shadow copy of the bank, and only the
//   differing bits are pulsed (set or reset, never both) for HOLD_CYC cycles. SETTLE_CYC
//   quiet cycles follow, then done pulses for one cycle.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high reset (shared with the SR bank)
//   req_valid  in   request present
//   req_ready  out  driver can accept (high only in idle)
//   req_data   in   target bank value
//   req_clear  in   force target to all-zero, req_data ignored
//   s_out      out  per-bit set commands
//   r_out      out  per-bit reset commands
//   shadow_q   out  driver's copy of the bank's q outputs
//   busy       out  high while driving or settling
//   done       out  1-cycle pulse: command complete (or no-op)
//   nochange   out  1-cycle pulse with done when target equals shadow_q
module sr_bank_driver #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned HOLD_CYC   = 2,
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic             req_clear,
    output logic [WIDTH-1:0] s_out,
    output logic [WIDTH-1:0] r_out,
    output logic [WIDTH-1:0] shadow_q,
    output logic             busy,
    output logic             done,
    output logic             nochange
);

    localparam int unsigned MaxCyc = (HOLD_CYC > SETTLE_CYC) ? HOLD_CYC : SETTLE_CYC;
    localparam int unsigned CntW   = $clog2(MaxCyc + 1);
    localparam int unsigned HoldInt   = HOLD_CYC - 1;
    localparam int unsigned SettleInt = (SETTLE_CYC == 0) ? 0 : SETTLE_CYC - 1;
    localparam logic [CntW-1:0] HoldLoad   = HoldInt[CntW-1:0];
    localparam logic [CntW-1:0] SettleLoad = SettleInt[CntW-1:0];

    typedef enum logic [1:0] {StIdle, StDrive, StSettle} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  target_q, target_d;
    logic [WIDTH-1:0]  s_d, r_d, shadow_d;
    logic              busy_d, done_d, nochange_d, ready_d;

    logic              accept;
    logic [WIDTH-1:0]  req_target, set_mask, rst_mask;
    logic              no_diff;

    assign accept     = req_valid & req_ready;
    assign req_target = req_clear ? '0 : req_data;
    // Set and reset masks are disjoint by construction, so "11" can never be issued.
    assign set_mask   = req_target & ~shadow_q;
    assign rst_mask   = ~req_target & shadow_q;
    assign no_diff    = (set_mask == '0) && (rst_mask == '0);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept && !no_diff) state_d = StDrive;
            end
            StDrive: begin
                if (cnt_q == '0) state_d = (SETTLE_CYC == 0) ? StIdle : StSettle;
            end
            StSettle: begin
                if (cnt_q == '0) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs and datapath
    always_comb begin
        s_d        = s_out;
        r_d        = r_out;
        shadow_d   = shadow_q;
        target_d   = target_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        nochange_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (no_diff) begin
                        done_d     = 1'b1;
                        nochange_d = 1'b1;
                    end else begin
                        s_d      = set_mask;
                        r_d      = rst_mask;
                        target_d = req_target;
                        cnt_d    = HoldLoad;
                    end
                end
            end
            StDrive: begin
                if (cnt_q == '0) begin
                    s_d      = '0;
                    r_d      = '0;
                    shadow_d = target_q;
                    if (SETTLE_CYC == 0) done_d = 1'b1;
                    else                 cnt_d  = SettleLoad;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StSettle: begin
                if (cnt_q == '0) done_d = 1'b1;
                else             cnt_d  = cnt_q - 1'b1;
            end
            default: begin
                s_d = '0;
                r_d = '0;
            end
        endcase
        busy_d  = (state_d != StIdle);
        ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_out     <= '0;
            r_out     <= '0;
            shadow_q  <= '0;
            target_q  <= '0;
            cnt_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            nochange  <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            s_out     <= s_d;
            r_out     <= r_d;
            shadow_q  <= shadow_d;
            target_q  <= target_d;
            cnt_q     <= cnt_d;
            busy      <= busy_d;
            done      <= done_d;
            nochange  <= nochange_d;
            req_ready <= ready_d;
        end
    end

endmodule
